// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset control FSM: opcodes,
// state encoding, datapath select codes and the per-state control vector.
package multicycle_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    // fetch marks the state whose IR/PC writes are qualified by mem_ready
    typedef struct packed {
        logic       mem_req;
        logic       memwrite;
        logic       iord;
        logic       fetch;
        logic       pcwrite;
        logic       branch;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] opc);
        logic legal;
        case (opc)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: legal = 1'b1;
            default:                                        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mc_state_dec.sv
// Combinational decoder from the FSM state to the datapath control vector.
// Unlisted signals stay 0; unreachable encodings decode to all zeros.
module mc_state_dec
    import multicycle_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    // Per-state Moore control decode
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req = 1'b1;
                ctrl.fetch   = 1'b1;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.pcsrc   = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl.alusrcb = SRCB_IMMSH;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_req  = 1'b1;
                ctrl.memwrite = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_REGB;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_REGB;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = PCSRC_ALUOUT;
                ctrl.branch  = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl.regwrite = 1'b1;
            end
            S_JUMP: begin
                ctrl.pcsrc   = PCSRC_JUMP;
                ctrl.pcwrite = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: state register, next-state sequencing with memory
// stalls, and input-qualified IR/PC/illegal strobes on top of the state decode.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int OPW    = 6,
    parameter int ALUOPW = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OPW-1:0]    op,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              memwrite,
    output logic              iord,
    output logic              irwrite,
    output logic              pcen,
    output logic              regwrite,
    output logic              regdst,
    output logic              memtoreg,
    output logic              alusrca,
    output logic [1:0]        alusrcb,
    output logic [ALUOPW-1:0] aluop,
    output logic [1:0]        pcsrc,
    output logic              illegal
);

    state_t     state_r;
    state_t     next_state_s;
    ctrl_t      ctrl_s;
    logic [5:0] opcode_s;

    assign opcode_s = 6'(op);

    mc_state_dec u_dec (
        .state (state_r),
        .ctrl  (ctrl_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state sequencing; memory states hold until mem_ready
    always_comb begin
        next_state_s = S_FETCH;
        case (state_r)
            S_FETCH: begin
                if (mem_ready) next_state_s = S_DECODE;
                else           next_state_s = S_FETCH;
            end
            S_DECODE: begin
                case (opcode_s)
                    OP_LW, OP_SW: next_state_s = S_MEMADR;
                    OP_RTYPE:     next_state_s = S_EXECUTE;
                    OP_BEQ:       next_state_s = S_BRANCH;
                    OP_ADDI:      next_state_s = S_ADDIEX;
                    OP_J:         next_state_s = S_JUMP;
                    default:      next_state_s = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (opcode_s == OP_SW) next_state_s = S_MEMWR;
                else                   next_state_s = S_MEMRD;
            end
            S_MEMRD: begin
                if (mem_ready) next_state_s = S_MEMWB;
                else           next_state_s = S_MEMRD;
            end
            S_MEMWR: begin
                if (mem_ready) next_state_s = S_FETCH;
                else           next_state_s = S_MEMWR;
            end
            S_EXECUTE: next_state_s = S_ALUWB;
            S_ADDIEX:  next_state_s = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: next_state_s = S_FETCH;
            default:   next_state_s = S_FETCH;
        endcase
    end

    // Output drive: reset blanks everything, else decode plus gated strobes
    always_comb begin
        if (reset) begin
            mem_req  = 1'b0;
            memwrite = 1'b0;
            iord     = 1'b0;
            irwrite  = 1'b0;
            pcen     = 1'b0;
            regwrite = 1'b0;
            regdst   = 1'b0;
            memtoreg = 1'b0;
            alusrca  = 1'b0;
            alusrcb  = 2'b00;
            aluop    = '0;
            pcsrc    = 2'b00;
            illegal  = 1'b0;
        end else begin
            mem_req  = ctrl_s.mem_req;
            memwrite = ctrl_s.memwrite;
            iord     = ctrl_s.iord;
            irwrite  = ctrl_s.fetch & mem_ready;
            pcen     = ctrl_s.pcwrite | (ctrl_s.fetch & mem_ready) | (ctrl_s.branch & zero);
            regwrite = ctrl_s.regwrite;
            regdst   = ctrl_s.regdst;
            memtoreg = ctrl_s.memtoreg;
            alusrca  = ctrl_s.alusrca;
            alusrcb  = ctrl_s.alusrcb;
            aluop    = ALUOPW'(ctrl_s.aluop);
            pcsrc    = ctrl_s.pcsrc;
            illegal  = (state_r == S_DECODE) & ~op_legal(opcode_s);
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed per-cycle vector table,
// a mid-instruction reset sequence, and random instruction streams vs a phase model.
module tb_multicycle_ctrl;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_ADDI  = 6'b001000;
    localparam logic [5:0] T_J     = 6'b000010;
    localparam logic [5:0] T_BAD   = 6'b111111;

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic        z;
        logic [16:0] exp;
    } step_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg, alusrca, illegal;
    logic [1:0]  alusrcb, aluop, pcsrc;
    logic [16:0] outs;

    int checks = 0;
    int errors = 0;

    step_t vec[$];
    step_t rq[$];

    logic [16:0] e_fwait, e_fgo, e_dec, e_decill, e_madr, e_mrd, e_mwb, e_mwr;
    logic [16:0] e_exe, e_aluwb, e_br0, e_br1, e_aex, e_awb, e_jmp;

    multicycle_ctrl #(.OPW(6), .ALUOPW(2)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
        .pcen(pcen), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign outs = {mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg,
                   alusrca, alusrcb, aluop, pcsrc, illegal};

    function automatic logic [16:0] ctl(input logic mreq, mw, io, irw, pce, rw, rd, m2r, asa,
                                        input logic [1:0] asb, aop, psrc, input logic ill);
        return {mreq, mw, io, irw, pce, rw, rd, m2r, asa, asb, aop, psrc, ill};
    endfunction

    function automatic step_t mk(input logic [5:0] o, input logic r, input logic z, input logic [16:0] e);
        step_t s;
        s.op = o; s.rdy = r; s.z = z; s.exp = e;
        return s;
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic is_legal(input logic [5:0] o);
        return (o == T_RTYPE) || (o == T_LW) || (o == T_SW) ||
               (o == T_BEQ) || (o == T_ADDI) || (o == T_J);
    endfunction

    task automatic run_step(input step_t s, input string name, input int idx);
        @(negedge clk);
        reset = 1'b0; op = s.op; mem_ready = s.rdy; zero = s.z;
        #2;
        checks++;
        if (outs !== s.exp) begin
            errors++;
            $display("FAIL %s step=%0d op=%b rdy=%b z=%b got=%b want=%b",
                     name, idx, s.op, s.rdy, s.z, outs, s.exp);
        end
    endtask

    task automatic rst_step(input int idx);
        @(negedge clk);
        reset = 1'b1; op = 6'($urandom); mem_ready = rb(); zero = rb();
        #2;
        checks++;
        if (outs !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs step=%0d got=%b want=%b", idx, outs, 17'd0);
        end
    endtask

    // Reference model: expand one instruction into its expected cycle sequence
    task automatic gen_instr(input logic [5:0] o);
        int w;
        logic zz;
        w = $urandom_range(0, 3);
        for (int i = 0; i < w; i++) rq.push_back(mk(6'($urandom), 1'b0, rb(), e_fwait));
        rq.push_back(mk(6'($urandom), 1'b1, rb(), e_fgo));
        if (!is_legal(o)) begin
            rq.push_back(mk(o, rb(), rb(), e_decill));
            return;
        end
        rq.push_back(mk(o, rb(), rb(), e_dec));
        case (o)
            T_RTYPE: begin
                rq.push_back(mk(o, rb(), rb(), e_exe));
                rq.push_back(mk(o, rb(), rb(), e_aluwb));
            end
            T_LW, T_SW: begin
                rq.push_back(mk(o, rb(), rb(), e_madr));
                w = $urandom_range(0, 3);
                for (int i = 0; i < w; i++)
                    rq.push_back(mk(o, 1'b0, rb(), (o == T_LW) ? e_mrd : e_mwr));
                rq.push_back(mk(o, 1'b1, rb(), (o == T_LW) ? e_mrd : e_mwr));
                if (o == T_LW) rq.push_back(mk(o, rb(), rb(), e_mwb));
            end
            T_BEQ: begin
                zz = rb();
                rq.push_back(mk(o, rb(), zz, zz ? e_br1 : e_br0));
            end
            T_ADDI: begin
                rq.push_back(mk(o, rb(), rb(), e_aex));
                rq.push_back(mk(o, rb(), rb(), e_awb));
            end
            default: rq.push_back(mk(o, rb(), rb(), e_jmp));
        endcase
    endtask

    initial begin
        //              mrq mw io irw pce rw rd m2r asa asb    aop    psrc  ill
        e_fwait  = ctl(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
        e_fgo    = ctl(1, 0, 0, 1, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
        e_dec    = ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0);
        e_decill = ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 1);
        e_madr   = ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
        e_mrd    = ctl(1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        e_mwb    = ctl(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
        e_mwr    = ctl(1, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        e_exe    = ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0);
        e_aluwb  = ctl(0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        e_br0    = ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0);
        e_br1    = ctl(0, 0, 0, 0, 1, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0);
        e_aex    = ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
        e_awb    = ctl(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        e_jmp    = ctl(0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0);

        // Directed per-cycle table (op, mem_ready, zero, expected outputs)
        vec.push_back(mk(T_RTYPE, 1'b0, 1'b0, e_fwait));
        vec.push_back(mk(T_RTYPE, 1'b1, 1'b0, e_fgo));      // R-type: 4 cycles
        vec.push_back(mk(T_RTYPE, 1'b0, 1'b1, e_dec));
        vec.push_back(mk(T_RTYPE, 1'b1, 1'b1, e_exe));
        vec.push_back(mk(T_RTYPE, 1'b1, 1'b0, e_aluwb));
        vec.push_back(mk(T_LW,    1'b1, 1'b0, e_fgo));      // LW with 2 wait cycles: 7
        vec.push_back(mk(T_LW,    1'b1, 1'b0, e_dec));
        vec.push_back(mk(T_LW,    1'b0, 1'b0, e_madr));
        vec.push_back(mk(T_LW,    1'b0, 1'b1, e_mrd));
        vec.push_back(mk(T_LW,    1'b0, 1'b0, e_mrd));
        vec.push_back(mk(T_LW,    1'b1, 1'b0, e_mrd));
        vec.push_back(mk(T_LW,    1'b0, 1'b1, e_mwb));
        vec.push_back(mk(T_BEQ,   1'b1, 1'b0, e_fgo));      // BEQ taken
        vec.push_back(mk(T_BEQ,   1'b1, 1'b1, e_dec));
        vec.push_back(mk(T_BEQ,   1'b0, 1'b1, e_br1));
        vec.push_back(mk(T_BEQ,   1'b1, 1'b1, e_fgo));      // BEQ not taken
        vec.push_back(mk(T_BEQ,   1'b1, 1'b0, e_dec));
        vec.push_back(mk(T_BEQ,   1'b1, 1'b0, e_br0));
        vec.push_back(mk(T_SW,    1'b1, 1'b0, e_fgo));      // SW
        vec.push_back(mk(T_SW,    1'b1, 1'b0, e_dec));
        vec.push_back(mk(T_SW,    1'b1, 1'b0, e_madr));
        vec.push_back(mk(T_SW,    1'b0, 1'b0, e_mwr));
        vec.push_back(mk(T_SW,    1'b1, 1'b0, e_mwr));
        vec.push_back(mk(T_J,     1'b1, 1'b0, e_fgo));      // J
        vec.push_back(mk(T_J,     1'b0, 1'b0, e_dec));
        vec.push_back(mk(T_J,     1'b0, 1'b0, e_jmp));
        vec.push_back(mk(T_ADDI,  1'b1, 1'b0, e_fgo));      // ADDI
        vec.push_back(mk(T_ADDI,  1'b1, 1'b0, e_dec));
        vec.push_back(mk(T_ADDI,  1'b1, 1'b1, e_aex));
        vec.push_back(mk(T_ADDI,  1'b1, 1'b1, e_awb));
        vec.push_back(mk(T_BAD,   1'b1, 1'b1, e_fgo));      // illegal: 2 cycles
        vec.push_back(mk(T_BAD,   1'b1, 1'b1, e_decill));
        vec.push_back(mk(T_BAD,   1'b0, 1'b1, e_fwait));
        vec.push_back(mk(T_BAD,   1'b0, 1'b1, e_fwait));

        reset = 1'b1; op = 6'd0; zero = 1'b0; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) rst_step(i);
        for (int i = 0; i < vec.size(); i++) run_step(vec[i], "directed", i);

        // Reset in the middle of a stalled LW read
        run_step(mk(T_LW, 1'b1, 1'b0, e_fgo),  "rst_seq", 0);
        run_step(mk(T_LW, 1'b0, 1'b0, e_dec),  "rst_seq", 1);
        run_step(mk(T_LW, 1'b0, 1'b0, e_madr), "rst_seq", 2);
        run_step(mk(T_LW, 1'b0, 1'b0, e_mrd),  "rst_seq", 3);
        rst_step(10);
        rst_step(11);
        run_step(mk(T_LW, 1'b0, 1'b0, e_fwait), "rst_release", 0);
        run_step(mk(T_LW, 1'b1, 1'b0, e_fgo),   "rst_release", 1);
        run_step(mk(T_LW, 1'b1, 1'b0, e_dec),   "rst_release", 2);
        run_step(mk(T_LW, 1'b1, 1'b0, e_madr),  "rst_release", 3);
        run_step(mk(T_LW, 1'b1, 1'b0, e_mrd),   "rst_release", 4);
        run_step(mk(T_LW, 1'b1, 1'b0, e_mwb),   "rst_release", 5);

        // Random instruction stream, mostly legal opcodes
        for (int n = 0; n < 300; n++) begin
            logic [5:0] o;
            case ($urandom_range(0, 6))
                0:       o = T_RTYPE;
                1:       o = T_LW;
                2:       o = T_SW;
                3:       o = T_BEQ;
                4:       o = T_ADDI;
                5:       o = T_J;
                default: o = 6'($urandom);
            endcase
            gen_instr(o);
        end
        rq.push_back(mk(6'd0, 1'b0, 1'b0, e_fwait));
        for (int i = 0; i < rq.size(); i++) run_step(rq[i], "random", i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
